// File: rtl/gat_pkg.sv
// Shared types and sizing for the GAT H-path blocks: bank geometry, row_info layout,
// streamed nonzero beat format and the row streamer FSM states.
package gat_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned NUM_OF_ROWS    = 5;
  localparam int unsigned NUM_OF_COLS    = 5;
  localparam int unsigned COL_IDX_WIDTH  = $clog2(NUM_OF_COLS);
  localparam int unsigned ROW_LEN_WIDTH  = $clog2(NUM_OF_COLS);
  localparam int unsigned ROW_INFO_WIDTH = ROW_LEN_WIDTH + 1;
  localparam int unsigned ROW_IDX_WIDTH  = $clog2(NUM_OF_ROWS);

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0] row_len;
    logic                     flag;
  } row_info_t;

  typedef struct packed {
    logic [ROW_IDX_WIDTH-1:0] row;
    logic [COL_IDX_WIDTH-1:0] col_idx;
    logic [DATA_WIDTH-1:0]    value;
    logic                     last;
    logic                     empty;
    logic                     flag;
  } nz_beat_t;

  typedef enum logic {
    IDLE,
    STREAM
  } streamer_state_e;

  // The row_len field can encode more than NUM_OF_COLS; anything larger means a full row.
  function automatic logic [ROW_LEN_WIDTH-1:0] clamp_len(input logic [ROW_LEN_WIDTH-1:0] row_len);
    if (row_len > ROW_LEN_WIDTH'(NUM_OF_COLS)) begin
      return ROW_LEN_WIDTH'(NUM_OF_COLS);
    end
    return row_len;
  endfunction

endpackage

// File: rtl/h_row_streamer_ctrl.sv
// Sequencing for h_row_streamer: bank capture handshake, per-beat row/col walk and the
// end-of-bank done pulse.
module h_row_streamer_ctrl
  import gat_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic                     nz_ready_i,
  output logic                     nz_valid_o,
  input  logic                     row_last_i,
  output logic                     capture_o,
  output logic [ROW_IDX_WIDTH-1:0] row_cnt_o,
  output logic [COL_IDX_WIDTH-1:0] col_cnt_o,
  output logic                     done_o
);

  streamer_state_e          state_q, state_d;
  logic [ROW_IDX_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [COL_IDX_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic                     done_q, done_d;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    done_d     = 1'b0;
    ld_ready_o = 1'b0;
    nz_valid_o = 1'b0;
    capture_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          capture_o = 1'b1;
          row_cnt_d = '0;
          col_cnt_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        nz_valid_o = 1'b1;
        if (nz_ready_i) begin
          // Compare before increment, so neither counter ever runs past its last index.
          if (row_last_i) begin
            col_cnt_d = '0;
            if (row_cnt_q == ROW_IDX_WIDTH'(NUM_OF_ROWS - 1)) begin
              row_cnt_d = '0;
              done_d    = 1'b1;
              state_d   = IDLE;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      done_q    <= done_d;
    end
  end

  assign row_cnt_o = row_cnt_q;
  assign col_cnt_o = col_cnt_q;
  assign done_o    = done_q;

endmodule

// File: rtl/h_row_streamer.sv
// Captures one bank of unpacked CSR rows from the H loader and streams it out as one
// nonzero per beat, tagged with row index, end-of-row and empty-row markers.
module h_row_streamer
  import gat_pkg::*;
(
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 ld_valid_i,
  output logic                                                 ld_ready_o,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] row_col_idx_i,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    row_value_i,
  input  logic [NUM_OF_ROWS-1:0][ROW_INFO_WIDTH-1:0]                 row_info_i,
  output logic                                                 nz_valid_o,
  input  logic                                                 nz_ready_i,
  output logic [ROW_IDX_WIDTH-1:0]                             nz_row_o,
  output logic [COL_IDX_WIDTH-1:0]                             nz_col_idx_o,
  output logic [DATA_WIDTH-1:0]                                nz_value_o,
  output logic                                                 nz_last_o,
  output logic                                                 nz_empty_o,
  output logic                                                 nz_flag_o,
  output logic                                                 done_o
);

  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] col_idx_q;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    value_q;
  logic [NUM_OF_ROWS-1:0][ROW_INFO_WIDTH-1:0]                 info_q;

  logic                     capture;
  logic                     valid;
  logic                     row_last;
  logic [ROW_IDX_WIDTH-1:0] row_cnt;
  logic [COL_IDX_WIDTH-1:0] col_cnt;
  row_info_t                cur_info;
  logic [ROW_LEN_WIDTH-1:0] cur_len;
  logic                     cur_empty;
  nz_beat_t                 beat;

  h_row_streamer_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .nz_ready_i (nz_ready_i),
    .nz_valid_o (valid),
    .row_last_i (row_last),
    .capture_o  (capture),
    .row_cnt_o  (row_cnt),
    .col_cnt_o  (col_cnt),
    .done_o     (done_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx_q <= '0;
      value_q   <= '0;
      info_q    <= '0;
    end else if (capture) begin
      col_idx_q <= row_col_idx_i;
      value_q   <= row_value_i;
      info_q    <= row_info_i;
    end
  end

  always_comb begin
    cur_info  = row_info_t'(info_q[row_cnt]);
    cur_len   = clamp_len(cur_info.row_len);
    cur_empty = (cur_len == '0);
    row_last  = cur_empty || (col_cnt == COL_IDX_WIDTH'(cur_len - 1'b1));
    // Outside STREAM the beat is forced to zero so stale bank contents never leak out.
    beat = '0;
    if (valid) begin
      beat.row     = row_cnt;
      beat.col_idx = cur_empty ? '0 : col_idx_q[row_cnt][col_cnt];
      beat.value   = cur_empty ? '0 : value_q[row_cnt][col_cnt];
      beat.last    = row_last;
      beat.empty   = cur_empty;
      beat.flag    = cur_info.flag;
    end
  end

  assign nz_valid_o   = valid;
  assign nz_row_o     = beat.row;
  assign nz_col_idx_o = beat.col_idx;
  assign nz_value_o   = beat.value;
  assign nz_last_o    = beat.last;
  assign nz_empty_o   = beat.empty;
  assign nz_flag_o    = beat.flag;

endmodule

// File: tb/tb_h_row_streamer.sv
// Randomized bench for h_row_streamer: each bank is expanded into its expected beat list
// from the CSR rules and compared beat by beat, including stall and bank-end behaviour.
module tb_h_row_streamer;
  import gat_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ld_valid_i = 1'b0;
  logic ld_ready_o;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] row_col_idx_i = '0;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    row_value_i = '0;
  logic [NUM_OF_ROWS-1:0][ROW_INFO_WIDTH-1:0]                 row_info_i = '0;
  logic nz_valid_o;
  logic nz_ready_i = 1'b0;
  logic [ROW_IDX_WIDTH-1:0] nz_row_o;
  logic [COL_IDX_WIDTH-1:0] nz_col_idx_o;
  logic [DATA_WIDTH-1:0]    nz_value_o;
  logic nz_last_o, nz_empty_o, nz_flag_o, done_o;

  int vectors = 0;
  int miscompares = 0;
  nz_beat_t exp_q[$];

  h_row_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_valid_i    (ld_valid_i),
    .ld_ready_o    (ld_ready_o),
    .row_col_idx_i (row_col_idx_i),
    .row_value_i   (row_value_i),
    .row_info_i    (row_info_i),
    .nz_valid_o    (nz_valid_o),
    .nz_ready_i    (nz_ready_i),
    .nz_row_o      (nz_row_o),
    .nz_col_idx_o  (nz_col_idx_o),
    .nz_value_o    (nz_value_o),
    .nz_last_o     (nz_last_o),
    .nz_empty_o    (nz_empty_o),
    .nz_flag_o     (nz_flag_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic randomize_bank(input int max_len);
    for (int r = 0; r < NUM_OF_ROWS; r++) begin
      for (int c = 0; c < NUM_OF_COLS; c++) begin
        row_col_idx_i[r][c] = COL_IDX_WIDTH'($urandom_range(0, NUM_OF_COLS - 1));
        row_value_i[r][c]   = DATA_WIDTH'($urandom);
      end
      row_info_i[r] = {ROW_LEN_WIDTH'($urandom_range(0, max_len)), 1'($urandom_range(0, 1))};
    end
  endtask

  task automatic set_info(input int r, input int len, input logic flag);
    row_info_i[r] = {ROW_LEN_WIDTH'(len), flag};
  endtask

  // Expected stream: every row gives max(min(row_len, NUM_OF_COLS), 1) beats.
  task automatic build_model();
    nz_beat_t e;
    int len;
    exp_q.delete();
    for (int r = 0; r < NUM_OF_ROWS; r++) begin
      len = int'(row_info_i[r][ROW_INFO_WIDTH-1:1]);
      if (len > NUM_OF_COLS) len = NUM_OF_COLS;
      if (len == 0) begin
        e = '{row: ROW_IDX_WIDTH'(r), col_idx: '0, value: '0, last: 1'b1, empty: 1'b1,
              flag: row_info_i[r][0]};
        exp_q.push_back(e);
      end
      for (int c = 0; c < len; c++) begin
        e = '{row: ROW_IDX_WIDTH'(r), col_idx: row_col_idx_i[r][c], value: row_value_i[r][c],
              last: (c == len - 1), empty: 1'b0, flag: row_info_i[r][0]};
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge right after capture.
  task automatic start_bank(input logic hold_valid);
    build_model();
    vectors++;
    if (ld_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ld_ready_idle: got %b want 1", ld_ready_o);
    end
    ld_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_valid_i = hold_valid;
  endtask

  // Streams the whole expected queue, then checks the done cycle at the final negedge.
  task automatic drain(input int mode);
    int k = 0;
    logic xfer;
    nz_beat_t got;
    while (exp_q.size() > 0 && k < 400) begin
      nz_ready_i = ready_for(mode, k);
      got = {nz_row_o, nz_col_idx_o, nz_value_o, nz_last_o, nz_empty_o, nz_flag_o};
      vectors++;
      if (nz_valid_o !== 1'b1 || got !== exp_q[0] || done_o !== 1'b0 || ld_ready_o !== 1'b0)
      begin
        miscompares++;
        $display("FAIL beat k=%0d: got v=%b row=%0d col=%0d val=%0h last=%b empty=%b flag=%b done=%b rdy=%b want v=1 row=%0d col=%0d val=%0h last=%b empty=%b flag=%b done=0 rdy=0",
                 k, nz_valid_o, got.row, got.col_idx, got.value, got.last, got.empty, got.flag,
                 done_o, ld_ready_o, exp_q[0].row, exp_q[0].col_idx, exp_q[0].value,
                 exp_q[0].last, exp_q[0].empty, exp_q[0].flag);
      end
      xfer = nz_valid_o && nz_ready_i;
      @(posedge clk);
      if (xfer) void'(exp_q.pop_front());
      @(negedge clk);
      k++;
    end
    nz_ready_i = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (done_o !== 1'b1 || nz_valid_o !== 1'b0 || ld_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bank_end: got done=%b valid=%b rdy=%b want done=1 valid=0 rdy=1",
               done_o, nz_valid_o, ld_ready_o);
    end
  endtask

  task automatic check_done_low(input string name);
    vectors++;
    if (done_o !== 1'b0 || nz_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got done=%b valid=%b want done=0 valid=0", name, done_o, nz_valid_o);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (ld_ready_o !== 1'b1 || nz_valid_o !== 1'b0 || done_o !== 1'b0 ||
        {nz_row_o, nz_col_idx_o, nz_value_o, nz_last_o, nz_empty_o, nz_flag_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b valid=%b done=%b data=%h want rdy=1 valid=0 done=0 data=0",
               ld_ready_o, nz_valid_o, done_o,
               {nz_row_o, nz_col_idx_o, nz_value_o, nz_last_o, nz_empty_o, nz_flag_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_done_low("post_reset");
  endtask

  task automatic load_fixed_bank();
    randomize_bank(0);
    set_info(0, 2, 1'b0);
    set_info(1, 1, 1'b1);
    set_info(2, 3, 1'b0);
    set_info(3, 0, 1'b1);
    set_info(4, 1, 1'b0);
  endtask

  task automatic test_basic();
    load_fixed_bank();
    start_bank(1'b0);
    vectors++;
    if (exp_q.size() != 8) begin
      miscompares++;
      $display("FAIL basic_beat_count: got %0d want 8", exp_q.size());
    end
    drain(0);
    @(negedge clk);
    check_done_low("basic_done_width");
  endtask

  task automatic test_stall();
    load_fixed_bank();
    start_bank(1'b0);
    drain(1);
    @(negedge clk);
  endtask

  task automatic test_clamp();
    randomize_bank(3);
    set_info(2, 7, 1'b1);
    start_bank(1'b0);
    drain(2);
    @(negedge clk);
  endtask

  task automatic test_all_empty();
    randomize_bank(0);
    for (int r = 0; r < NUM_OF_ROWS; r++) set_info(r, 0, 1'b1);
    start_bank(1'b0);
    drain(0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    randomize_bank(7);
    start_bank(1'b1);
    // Loader keeps presenting a new bank while the first one streams.
    randomize_bank(7);
    drain(0);
    build_model();
    @(posedge clk);
    @(negedge clk);
    ld_valid_i = 1'b0;
    drain(2);
    @(negedge clk);
    check_done_low("b2b_idle");
  endtask

  task automatic test_reset_mid();
    randomize_bank(0);
    for (int r = 0; r < NUM_OF_ROWS; r++) set_info(r, 3, 1'b0);
    start_bank(1'b0);
    nz_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (nz_valid_o !== 1'b0 || ld_ready_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b rdy=%b done=%b want valid=0 rdy=1 done=0",
               nz_valid_o, ld_ready_o, done_o);
    end
    nz_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_done_low("reset_mid_no_done");
    end
    randomize_bank(7);
    start_bank(1'b0);
    drain(0);
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      randomize_bank(7);
      start_bank(1'b0);
      drain(2);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clamp();
    test_all_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/h_row_streamer.md
Name: h_row_streamer

Overview:
- Downstream neighbour of the H feature loader.
- Captures one bank of unpacked CSR rows (per-row column indices, values, row_info = [row_len, flag]) through a valid/ready handshake.
- Serialises the bank into a stream of one nonzero per beat, tagged with row index and end-of-row marker, for the SpMM accumulator (H x W stage).
- Holds the loader off until the whole bank has drained; pulses done at bank end.

Parameters:
- DATA_WIDTH, 8, element width of H values.
- NUM_OF_ROWS, 5, rows per bank.
- NUM_OF_COLS, 5, max nonzeros per row.
- COL_IDX_WIDTH, $clog2(NUM_OF_COLS), column index width.
- ROW_LEN_WIDTH, $clog2(NUM_OF_COLS), row length field width.
- ROW_INFO_WIDTH, ROW_LEN_WIDTH+1, [row_len, flag].
- ROW_IDX_WIDTH, $clog2(NUM_OF_ROWS), row index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid_i  in  1  loader bank valid.
- ld_ready_o  out  1  bank accepted when ld_valid_i && ld_ready_o at posedge.
- row_col_idx_i  in  [NUM_OF_ROWS][NUM_OF_COLS] x COL_IDX_WIDTH  column indices per row.
- row_value_i  in  [NUM_OF_ROWS][NUM_OF_COLS] x DATA_WIDTH  values per row.
- row_info_i  in  [NUM_OF_ROWS] x ROW_INFO_WIDTH  {row_len, flag}.
- nz_valid_o  out  1  output beat valid.
- nz_ready_i  in  1  downstream ready.
- nz_row_o  out  ROW_IDX_WIDTH  row index of beat.
- nz_col_idx_o  out  COL_IDX_WIDTH  column index (0 on empty-row beat).
- nz_value_o  out  DATA_WIDTH  value (0 on empty-row beat).
- nz_last_o  out  1  last beat of the row.
- nz_empty_o  out  1  row has row_len = 0.
- nz_flag_o  out  1  row_info flag of the row, constant across its beats.
- done_o  out  1  one-cycle pulse after final beat of bank accepted.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, ld_ready_o=1, nz_valid_o=0, nz_* data=0, done_o=0, counters=0, bank regs=0.
- FSM IDLE -> STREAM -> IDLE.
  - IDLE: ld_ready_o=1. On ld_valid_i, register all inputs into the bank, set row_cnt=0, col_cnt=0, and enter STREAM next cycle. Only the ld_valid_i && ld_ready_o handshake captures; there is no ld_ready combinational path from ld_valid_i.
  - STREAM: ld_ready_o=0. nz_valid_o=1 with the beat for (row_cnt, col_cnt) driven from registers. First beat is valid the cycle after capture (latency 1).
- Beat transfer occurs on nz_valid_o && nz_ready_i.
  - On transfer: if col_cnt == len-1 (or the row is empty), set col_cnt=0 and row_cnt++. Otherwise col_cnt++.
  - len = min(row_len, NUM_OF_COLS); out-of-range row_len is clamped.
- Empty row (len=0): exactly one beat with nz_empty_o=1, nz_last_o=1, col_idx=0, value=0.
- nz_last_o=1 when col_cnt == len-1, or the row is empty.
- Stall: while nz_valid_o && !nz_ready_i, all nz_* outputs hold stable. Back-to-back transfers sustain 1 beat/cycle.
- Bank end: the transfer of the last beat of row NUM_OF_ROWS-1 sets done_o=1 for the next cycle. In that same cycle state=IDLE, nz_valid_o=0, ld_ready_o=1.
  - A new bank can be captured in the done_o cycle, so there is 1 bubble cycle between banks.
- Total beats per bank = sum over rows of max(len,1).
- ld_valid_i in STREAM is ignored; the bank registers are not overwritten.
- Reset mid-stream: immediate return to reset values; the partial bank is discarded and no done_o is produced.
- Counters: row_cnt is ROW_IDX_WIDTH bits; col_cnt is COL_IDX_WIDTH bits. Neither wraps past its limit because the compare precedes the increment.

Decomposition:
- Shared package gat_pkg holds:
  - localparams NUM_OF_ROWS/NUM_OF_COLS/DATA_WIDTH and the derived widths.
  - typedef row_info_t {row_len, flag}.
  - typedef nz_beat_t {row, col_idx, value, last, empty, flag}.
  - enum streamer_state_e {IDLE, STREAM}.
- One sub-module is natural: h_row_streamer_ctrl. It holds the FSM plus row/col counters and emits select indices. The top holds the bank registers and the output mux/registers.

Test Plan:
- Bank with row_len = {2,1,3,0,1}, nz_ready_i=1 -> 8 beats.
  - Row 0: col_idx/value from cols 0..1, nz_last_o on beat 2.
  - Row 3: single beat, empty=1, last=1.
  - done_o pulses exactly 1 cycle after beat 8; first beat appears 1 cycle after capture.
- Same bank with nz_ready_i toggled 1,0,0,1 repeating -> identical 8-beat sequence; outputs stable during every stall cycle.
- row_len=7 on a row with NUM_OF_COLS=5 -> exactly 5 beats for that row, last on col 4.
- ld_valid_i held high continuously, two banks -> second capture occurs in the done_o cycle; no beats lost or duplicated. ld_valid_i changes during STREAM do not alter beats.
- All rows row_len=0, flag=1 -> 5 beats each with empty=1, last=1, flag=1; done_o after the 5th.
- rst_n asserted mid-bank after 3 beats -> nz_valid_o=0 and ld_ready_o=1 immediately (asynchronously); no done_o. The next bank streams from row 0.
